traffic_generator_local: RTL and testbench

Per-node packet injector. Drives the local input port of a mesh router, the upstream side of the router's local port. It builds single-word packets (destination, timestamp, packet ID, sender ID), paces them with a programmable gap, and hands each one over with a Req/Gnt handshake gated by the router's Full flag. Each node has one generator here and one collector on the router's local output port.

---
 rtl/traffic_generator_local_if.sv | 25 ++
 rtl/traffic_generator_local.sv | 141 ++++++++++++++
 tb/tb_traffic_generator_local.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_generator_local_if.sv
// Local-port link between a packet generator and its mesh router.
// The generator drives the request and the packet word; the router answers
// with a one-cycle grant and reports back-pressure through the full flag.
interface traffic_generator_local_if #(
    parameter int dataWidth = 32
);
    logic                 ReqDnStr;
    logic [dataWidth-1:0] PacketOut;
    logic                 GntDnStr;
    logic                 DnStrFull;

    modport master (
        output ReqDnStr,
        output PacketOut,
        input  GntDnStr,
        input  DnStrFull
    );

    modport slave (
        input  ReqDnStr,
        input  PacketOut,
        output GntDnStr,
        output DnStrFull
    );
endinterface

// File: rtl/traffic_generator_local.sv
// Per-node packet injector for the local input port of a mesh router.
// Builds single-word packets {dest, timestamp, packet id, sender id}, spaces
// them by a programmable idle gap and hands each over with Req/Gnt.
//
//   state | meaning
//   IDLE  | counting down the gap; requests once enabled, not full, gap expired
//   REQ   | packet presented and held until the router grants it
//   GAP   | single post-grant cycle; swallows a held grant, updates Done
module traffic_generator_local #(
    parameter logic [5:0]  routerID   = 6'b000_000,
    parameter logic [5:0]  ModuleID   = 6'b000_000,
    parameter int          dataWidth  = 32,
    parameter int          dim        = 4,
    parameter logic        DestMode   = 1'b1,
    parameter logic [5:0]  FixedDest  = 6'b011_011,
    parameter logic [7:0]  InjGap     = 8'd10,
    parameter logic [9:0]  MaxPackets = 10'd0,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic Enable,
    output logic Done,
    traffic_generator_local_if.master dnStr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] DimW = 4'(dim);

    state_t               state;
    state_t               stateNext;
    logic [31:0]          cycleCnt;
    logic [9:0]           packetId;
    logic [9:0]           sentCnt;
    logic [7:0]           gapCnt;
    logic [15:0]          lfsr;
    logic [15:0]          lfsrNext;
    logic                 reqReg;
    logic                 doneReg;
    logic [dataWidth-1:0] pktReg;
    logic [dataWidth-1:0] pktNext;
    logic                 loadPkt;
    logic                 accept;
    logic                 setDone;
    logic [2:0]           rawX;
    logic [2:0]           rawY;
    logic [2:0]           destX;
    logic [2:0]           destY;
    logic [5:0]           destId;
    logic                 unusedCycleHi;

    // Only the low ten bits of the free-running cycle counter reach the packet.
    assign unusedCycleHi = &{1'b0, cycleCnt[31:10]};

    // Fibonacci step for taps 16,14,13,11 in shift-right form.
    assign lfsrNext = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // Fold the LFSR fields onto the mesh and step off our own router.
    always_comb begin
        rawX   = lfsr[2:0];
        rawY   = lfsr[5:3];
        destX  = ({1'b0, rawX} >= DimW) ? 3'({1'b0, rawX} - DimW) : rawX;
        destY  = ({1'b0, rawY} >= DimW) ? 3'({1'b0, rawY} - DimW) : rawY;
        if ({destX, destY} == routerID) begin
            destY = (({1'b0, destY} + 4'd1) == DimW) ? 3'd0 : destY + 3'd1;
        end
        destId = DestMode ? {destX, destY} : FixedDest;
    end

    // Packet word captured at the moment the request is raised.
    assign pktNext = {destId, cycleCnt[9:0], packetId, ModuleID};

    // Next-state and control strobes for the handshake sequence.
    always_comb begin
        stateNext = state;
        loadPkt   = 1'b0;
        accept    = 1'b0;
        setDone   = 1'b0;
        case (state)
            IDLE: begin
                if (!doneReg && Enable && !dnStr.DnStrFull && (gapCnt == 8'd0)) begin
                    loadPkt   = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (dnStr.GntDnStr) begin
                    accept    = 1'b1;
                    stateNext = GAP;
                end
            end
            GAP: begin
                setDone   = (MaxPackets != 10'd0) && (sentCnt == MaxPackets);
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cycleCnt <= 32'd0;
            packetId <= 10'd0;
            sentCnt  <= 10'd0;
            gapCnt   <= 8'd0;
            lfsr     <= LfsrSeed;
            reqReg   <= 1'b0;
            doneReg  <= 1'b0;
            pktReg   <= '0;
        end else begin
            state    <= stateNext;
            cycleCnt <= cycleCnt + 32'd1;
            if (loadPkt) begin
                pktReg <= pktNext;
                reqReg <= 1'b1;
            end
            if (accept) begin
                reqReg   <= 1'b0;
                packetId <= packetId + 10'd1;
                sentCnt  <= sentCnt + 10'd1;
                lfsr     <= lfsrNext;
                gapCnt   <= InjGap;
            end else if ((state == IDLE) && (gapCnt != 8'd0)) begin
                gapCnt <= gapCnt - 8'd1;
            end
            if (setDone) begin
                doneReg <= 1'b1;
            end
        end
    end

    assign dnStr.ReqDnStr  = reqReg;
    assign dnStr.PacketOut = pktReg;
    assign Done            = doneReg;
endmodule

// File: tb/tb_traffic_generator_local.sv
// Bench for traffic_generator_local: three generators with different
// parameter sets share one clock and reset; tests run one generator at a time.
// Expected packets go into a scoreboard queue; a monitor pops on each new request.
module tb_traffic_generator_local;
    typedef struct packed {
        logic [1:0] inst;
        logic [5:0] dest;
        logic [9:0] id;
        logic [5:0] mod;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [2:0]       en, full, forceGnt, respGnt, gnt, req, done;
    logic [2:0][31:0] pkt;
    logic [31:0]      tbCycle;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          gntLat = 0;
    int          gntLen = 1;
    int          reqAge[3], holdCnt[3];
    int          acc[3], riseCnt[3];
    logic [31:0] lastAcc[3], lastRise[3], held[3];
    logic [2:0]  reqPrev;
    int          expSpacing[3], spacingBase[3];

    traffic_generator_local_if #(.dataWidth(32)) if0 (), if1 (), if2 ();

    traffic_generator_local #(
        .routerID(6'b000_000), .ModuleID(6'b000_001), .dataWidth(32), .dim(4),
        .DestMode(1'b0), .FixedDest(6'b011_011), .InjGap(8'd10), .MaxPackets(10'd0),
        .LfsrSeed(16'hACE1)
    ) dut0 (.clk(clk), .reset(reset), .Enable(en[0]), .Done(done[0]), .dnStr(if0));

    traffic_generator_local #(
        .routerID(6'b101_000), .ModuleID(6'h2A), .dataWidth(32), .dim(6),
        .DestMode(1'b1), .FixedDest(6'b011_011), .InjGap(8'd0), .MaxPackets(10'd4),
        .LfsrSeed(16'hACE1)
    ) dut1 (.clk(clk), .reset(reset), .Enable(en[1]), .Done(done[1]), .dnStr(if1));

    traffic_generator_local #(
        .routerID(6'b001_010), .ModuleID(6'h15), .dataWidth(32), .dim(4),
        .DestMode(1'b1), .FixedDest(6'b011_011), .InjGap(8'd0), .MaxPackets(10'd0),
        .LfsrSeed(16'hACE1)
    ) dut2 (.clk(clk), .reset(reset), .Enable(en[2]), .Done(done[2]), .dnStr(if2));

    assign gnt = respGnt | forceGnt;
    assign if0.GntDnStr = gnt[0];
    assign if1.GntDnStr = gnt[1];
    assign if2.GntDnStr = gnt[2];
    assign if0.DnStrFull = full[0];
    assign if1.DnStrFull = full[1];
    assign if2.DnStrFull = full[2];
    assign req = {if2.ReqDnStr, if1.ReqDnStr, if0.ReqDnStr};
    assign pkt[0] = if0.PacketOut;
    assign pkt[1] = if1.PacketOut;
    assign pkt[2] = if2.PacketOut;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench copy of the free-running cycle counter
    always @(posedge clk or posedge reset) begin
        if (reset) tbCycle <= 32'd0;
        else       tbCycle <= tbCycle + 32'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [5:0] destOf(input logic [15:0] l, input int d, input logic [5:0] rid);
        int x, y;
        x = int'(l[2:0]) % d;
        y = int'(l[5:3]) % d;
        if ({x[2:0], y[2:0]} == rid) y = (y + 1) % d;
        return {x[2:0], y[2:0]};
    endfunction

    task automatic push(input int inst, input logic [5:0] dest, input int id, input logic [5:0] mod);
        exp_t e;
        e.inst = 2'(inst);
        e.dest = dest;
        e.id   = 10'(id);
        e.mod  = mod;
        expQ.push_back(e);
    endtask

    task automatic waitAcc(input int i, input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (acc[i] < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(acc[i]), 32'(n));
    endtask

    // Router model: grant gntLat cycles into a request, held gntLen cycles
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (holdCnt[i] != 0) begin
                respGnt[i] = 1'b1;
                holdCnt[i] = holdCnt[i] - 1;
            end else if (req[i] && !respGnt[i] && reqAge[i] >= gntLat) begin
                respGnt[i] = 1'b1;
                holdCnt[i] = gntLen - 1;
            end else begin
                respGnt[i] = 1'b0;
            end
            reqAge[i] = req[i] ? reqAge[i] + 1 : 0;
        end
    end

    // Monitor: new request pops the scoreboard; falling request counts a handshake
    always @(negedge clk) begin
        if (reset) begin
            reqPrev = 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !reqPrev[i]) begin
                    if (expQ.size() == 0) begin
                        chk("unexpected packet", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = expQ.pop_front();
                        chk("inst", 32'(i), 32'(e.inst));
                        chk("dest", 32'(pkt[i][31:26]), 32'(e.dest));
                        chk("pktid", 32'(pkt[i][15:6]), 32'(e.id));
                        chk("sender", 32'(pkt[i][5:0]), 32'(e.mod));
                        chk("tstamp", 32'(pkt[i][25:16]), 32'(10'(tbCycle - 32'd1)));
                    end
                    if (i == 2) begin
                        chk("x<dim", 32'(pkt[i][31:29] < 3'd4), 32'd1);
                        chk("y<dim", 32'(pkt[i][28:26] < 3'd4), 32'd1);
                        chk("dest!=self", 32'(pkt[i][31:26] != 6'b001_010), 32'd1);
                    end
                    if (expSpacing[i] != 0 && riseCnt[i] > spacingBase[i])
                        chk("req spacing", tbCycle - lastRise[i], 32'(expSpacing[i]));
                    held[i]     = pkt[i];
                    lastRise[i] = tbCycle;
                    riseCnt[i]++;
                end else if (req[i] && reqPrev[i]) begin
                    chk("pkt stable", pkt[i], held[i]);
                end
                if (!req[i] && reqPrev[i]) begin
                    acc[i]++;
                    lastAcc[i] = tbCycle;
                end
                reqPrev[i] = req[i];
            end
        end
    end

    initial begin
        logic [15:0] l;
        int          c;
        reset = 1'b1;
        en = 3'b000;
        full = 3'b000;
        forceGnt = 3'b000;
        respGnt = 3'b000;
        reqPrev = 3'b000;
        for (int i = 0; i < 3; i++) begin
            reqAge[i] = 0; holdCnt[i] = 0; acc[i] = 0; riseCnt[i] = 0;
            lastAcc[i] = 0; lastRise[i] = 0; held[i] = 0;
            expSpacing[i] = 0; spacingBase[i] = 0;
        end

        // Test 1: reset values, quiet while disabled, async drop of a request
        repeat (3) @(negedge clk);
        chk("rst req", 32'(req), 32'd0);
        chk("rst pkt", pkt[0] | pkt[1] | pkt[2], 32'd0);
        chk("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("idle req", 32'(req), 32'd0);
            chk("idle pkt", pkt[0], 32'd0);
            chk("idle done", 32'(done), 32'd0);
        end
        gntLat = 100;
        push(0, 6'b011_011, 0, 6'b000_001);
        en[0] = 1'b1;
        c = 0;
        while (!req[0] && c < 10) begin @(negedge clk); c++; end
        chk("t1 req up", 32'(req[0]), 32'd1);
        #2 reset = 1'b1;
        #1 chk("async req drop", 32'(req[0]), 32'd0);
        chk("async pkt clr", pkt[0], 32'd0);
        en[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Test 2: fixed destination, grant one cycle after request, gap 10
        gntLat = 0;
        spacingBase[0] = riseCnt[0];
        expSpacing[0] = 13;
        for (int k = 0; k < 3; k++) push(0, 6'b011_011, k, 6'b000_001);
        en[0] = 1'b1;
        waitAcc(0, 3, 100, "t2 handshakes");
        en[0] = 1'b0;
        expSpacing[0] = 0;

        // Test 3: full blocks a new request but never withdraws a raised one
        full[0] = 1'b1;
        en[0] = 1'b1;
        push(0, 6'b011_011, 3, 6'b000_001);
        repeat (20) begin
            @(negedge clk);
            chk("full blocks", 32'(req[0]), 32'd0);
        end
        gntLat = 6;
        full[0] = 1'b0;
        @(negedge clk);
        chk("req after release", 32'(req[0]), 32'd1);
        full[0] = 1'b1;
        en[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("req held in full", 32'(req[0]), 32'd1);
        end
        waitAcc(0, 4, 50, "t3 handshake");
        full[0] = 1'b0;
        gntLat = 0;

        // Test 4: MaxPackets=4, gap 0, hand-computed random destinations (dim 6)
        spacingBase[1] = riseCnt[1];
        expSpacing[1] = 3;
        push(1, 6'b001_100, 0, 6'h2A);
        push(1, 6'b000_000, 1, 6'h2A);
        push(1, 6'b000_001, 2, 6'h2A);
        push(1, 6'b100_011, 3, 6'h2A);
        en[1] = 1'b1;
        c = 0;
        while (!done[1] && c < 200) begin @(negedge clk); c++; end
        chk("t4 done", 32'(done[1]), 32'd1);
        chk("t4 done delay", tbCycle - lastAcc[1], 32'd1);
        chk("t4 handshakes", 32'(acc[1]), 32'd4);
        repeat (100) begin
            @(negedge clk);
            chk("no req after done", 32'(req[1]), 32'd0);
        end
        chk("t4 final count", 32'(acc[1]), 32'd4);
        chk("t4 done sticky", 32'(done[1]), 32'd1);
        chk("t4 queue empty", 32'(expQ.size()), 32'd0);

        // Test 5: 1000 random destinations on a 4x4 mesh against the LFSR model
        spacingBase[2] = riseCnt[2];
        expSpacing[2] = 3;
        l = 16'hACE1;
        for (int k = 0; k < 1000; k++) begin
            push(2, destOf(l, 4, 6'b001_010), k, 6'h15);
            l = lfsrStep(l);
        end
        en[2] = 1'b1;
        waitAcc(2, 1000, 5000, "t5 handshakes");
        en[2] = 1'b0;
        chk("t5 queue empty", 32'(expQ.size()), 32'd0);
        chk("t5 done low", 32'(done[2]), 32'd0);

        // Test 6: two-cycle grants, spurious grants in IDLE, PacketID wrap
        gntLen = 2;
        spacingBase[0] = riseCnt[0];
        expSpacing[0] = 13;
        for (int k = 4; k < 1024; k++) push(0, 6'b011_011, k, 6'b000_001);
        push(0, 6'b011_011, 0, 6'b000_001);
        en[0] = 1'b1;
        c = 0;
        while (acc[0] < 1025 && c < 20000) begin
            @(negedge clk);
            forceGnt[0] = (!req[0] && (c % 7 == 3));
            c++;
        end
        forceGnt[0] = 1'b0;
        en[0] = 1'b0;
        chk("t6 handshakes", 32'(acc[0]), 32'd1025);
        chk("t6 queue empty", 32'(expQ.size()), 32'd0);
        chk("t6 done low", 32'(done[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
